// File: rtl/nlm_linebuf_ctrl_if.sv
// rtl/nlm_linebuf_ctrl_if.sv - pixel stream, SRAM command and window-tag bundle for nlm_linebuf_ctrl
//
// Purpose: groups the input pixel handshake, the line-buffer SRAM command bus
// and the window-extraction tags that nlm_linebuf_ctrl drives.
// Ports (signals):
//   in_valid_i / in_data_i / in_ready_o    raster pixel stream into the sequencer
//   sram_wr_en_o / sram_wr_addr_o / sram_wr_data_o   one-hot row write
//   sram_rd_en_o / sram_rd_addr_o / head_num_o       all-row column read + rotation
//   ref_vld_o / srh_vld_o / total_vld_o              slice valids
//   col_o / center_row_o                             tags of the current total slice
// Modports: master = sequencer side, slave = stream source / downstream side.

interface nlm_linebuf_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int SRAM_SIZE  = 18
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic [SRAM_SIZE-1:0]  sram_wr_en_o;
  logic [ADDR_WIDTH-1:0] sram_wr_addr_o;
  logic [DATA_WIDTH-1:0] sram_wr_data_o;
  logic                  sram_rd_en_o;
  logic [ADDR_WIDTH-1:0] sram_rd_addr_o;
  logic [4:0]            head_num_o;
  logic                  ref_vld_o;
  logic                  srh_vld_o;
  logic                  total_vld_o;
  logic [ADDR_WIDTH-1:0] col_o;
  logic [ADDR_WIDTH-1:0] center_row_o;

  modport master (
    input  in_valid_i, in_data_i,
    output in_ready_o,
    output sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o,
    output sram_rd_en_o, sram_rd_addr_o, head_num_o,
    output ref_vld_o, srh_vld_o, total_vld_o, col_o, center_row_o
  );

  modport slave (
    output in_valid_i, in_data_i,
    input  in_ready_o,
    input  sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o,
    input  sram_rd_en_o, sram_rd_addr_o, head_num_o,
    input  ref_vld_o, srh_vld_o, total_vld_o, col_o, center_row_o
  );
endinterface

// File: rtl/nlm_linebuf_ctrl.sv
// rtl/nlm_linebuf_ctrl.sv - NLM 18-row circular line-buffer sequencer and window tagger
//
// Purpose: writes each raster line into one of SRAM_SIZE rotating SRAM rows,
// issues the column reads plus head_num rotation once enough lines are held,
// scans one read-only line at frame end, and tags the extracted window slices.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle frame arm (honoured only in IDLE)
//   bus (master)      pixel stream, SRAM commands, slice valids and tags
//   busy_o            high outside IDLE
//   done_o            one-cycle end-of-frame pulse
//   err_o             sticky mid-line input gap flag

module nlm_linebuf_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int SRAM_SIZE  = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  nlm_linebuf_ctrl_if.master   bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(IMG_HEIGHT - 1);
  // Last line written before the buffer holds enough rows to start reading.
  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(SRAM_SIZE - 2);
  // Distance from the line being written to the window centre row.
  localparam logic [ADDR_WIDTH-1:0] CTR_OFF   = ADDR_WIDTH'(SRAM_SIZE / 2);
  localparam logic [ADDR_WIDTH-1:0] FLUSH_ROW = ADDR_WIDTH'(IMG_HEIGHT - SRAM_SIZE / 2);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [4:0]            LAST_ROW  = 5'(SRAM_SIZE - 1);

  // Read strobe shift pipeline: stage k is valid k+1 cycles after the read
  // command appears on the SRAM bus.
  localparam int PIPE_LEN = 8;
  localparam int REF_TAP  = 1;
  localparam int SRH_TAP  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [4:0]            wr_row_q, wr_row_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  in_ready_q, in_ready_d;

  logic [SRAM_SIZE-1:0]  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [4:0]            head_q, head_d;
  logic [ADDR_WIDTH-1:0] rd_row_q, rd_row_d;

  logic [PIPE_LEN-1:0]   vld_pipe_q, vld_pipe_d;
  logic [ADDR_WIDTH-1:0] col_pipe_q [PIPE_LEN];
  logic [ADDR_WIDTH-1:0] col_pipe_d [PIPE_LEN];
  logic [ADDR_WIDTH-1:0] row_pipe_q [PIPE_LEN];
  logic [ADDR_WIDTH-1:0] row_pipe_d [PIPE_LEN];

  logic                  accept;
  logic                  line_end;
  logic [4:0]            next_row;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    wr_row_d  = wr_row_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    head_d    = head_q;
    rd_row_d  = rd_row_q;

    accept   = in_ready_q & bus.in_valid_i;
    line_end = (col_q == LAST_COL);
    next_row = (wr_row_q == LAST_ROW) ? 5'd0 : wr_row_q + 5'd1;

    // Tags enter the pipeline only alongside a read, so idle stages carry zeros.
    vld_pipe_d    = {vld_pipe_q[PIPE_LEN-2:0], rd_en_q};
    col_pipe_d[0] = rd_en_q ? rd_addr_q : '0;
    row_pipe_d[0] = rd_en_q ? rd_row_q  : '0;
    for (int k = 1; k < PIPE_LEN; k++) begin
      col_pipe_d[k] = col_pipe_q[k-1];
      row_pipe_d[k] = row_pipe_q[k-1];
    end

    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the finished frame.
        if (start_i && !done_q) begin
          state_d  = ST_FILL;
          col_d    = '0;
          line_d   = '0;
          wr_row_d = '0;
          err_d    = 1'b0;
        end
      end

      ST_FILL, ST_RUN: begin
        if (accept) begin
          wr_en_d   = SRAM_SIZE'(1) << wr_row_q;
          wr_addr_d = col_q;
          wr_data_d = bus.in_data_i;
          if (state_q == ST_RUN) begin
            // Head is the row after the one being written: the oldest line held.
            rd_en_d   = 1'b1;
            rd_addr_d = col_q;
            head_d    = next_row;
            rd_row_d  = line_q - CTR_OFF;
          end
          if (line_end) begin
            col_d    = '0;
            line_d   = line_q + ONE_A;
            wr_row_d = next_row;
            if (state_q == ST_FILL && line_q == FILL_LAST) begin
              state_d = ST_RUN;
            end
            if (state_q == ST_RUN && line_q == LAST_LINE) begin
              state_d = ST_FLUSH;
            end
          end else begin
            col_d = col_q + ONE_A;
          end
        end else if (col_q != '0) begin
          // Mid-line gap: flag it and hold position until the stream resumes.
          err_d = 1'b1;
        end
      end

      ST_FLUSH: begin
        rd_en_d   = 1'b1;
        rd_addr_d = col_q;
        head_d    = next_row;
        rd_row_d  = FLUSH_ROW;
        if (line_end) begin
          col_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          col_d = col_q + ONE_A;
        end
      end

      ST_DRAIN: begin
        // Reads are contiguous, so the last total valid is alone in the pipe.
        if (vld_pipe_q[PIPE_LEN-1] && (vld_pipe_q[PIPE_LEN-2:0] == '0) && !rd_en_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_FILL) || (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      line_q     <= '0;
      wr_row_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      head_q     <= '0;
      rd_row_q   <= '0;
      vld_pipe_q <= '0;
      for (int k = 0; k < PIPE_LEN; k++) begin
        col_pipe_q[k] <= '0;
        row_pipe_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      wr_row_q   <= wr_row_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      head_q     <= head_d;
      rd_row_q   <= rd_row_d;
      vld_pipe_q <= vld_pipe_d;
      col_pipe_q <= col_pipe_d;
      row_pipe_q <= row_pipe_d;
    end
  end

  assign bus.in_ready_o     = in_ready_q;
  assign bus.sram_wr_en_o   = wr_en_q;
  assign bus.sram_wr_addr_o = wr_addr_q;
  assign bus.sram_wr_data_o = wr_data_q;
  assign bus.sram_rd_en_o   = rd_en_q;
  assign bus.sram_rd_addr_o = rd_addr_q;
  assign bus.head_num_o     = head_q;
  assign bus.ref_vld_o      = vld_pipe_q[REF_TAP];
  assign bus.srh_vld_o      = vld_pipe_q[SRH_TAP];
  assign bus.total_vld_o    = vld_pipe_q[PIPE_LEN-1];
  assign bus.col_o          = col_pipe_q[PIPE_LEN-1];
  assign bus.center_row_o   = row_pipe_q[PIPE_LEN-1];
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule
